wishbone_arbiter: RTL and testbench
===================================

Name: wishbone_arbiter

Overview:
Two-master round-robin arbiter for the 8-bit-data, 23-bit-address Wishbone classic bus. It shares the single slave port (SRAM/memory controller) between the UART debug bridge (master 0) and the Levenshtein compute engine (master 1). Grants are registered and held for a whole bus cycle. Slave responses are routed only to the granted master.

Parameters:
ADDR_WIDTH, 23, address width of every port
DATA_WIDTH, 8, data width of every port
TIMEOUT_CYCLES, 255, watchdog limit in clocks (used only with the optional feature)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous reset, active-low
m_cyc_i  in  2  per-master cycle request, bit n = master n
m_stb_i  in  2  per-master strobe
m_we_i  in  2  per-master write enable
m_adr_i  in  2*ADDR_WIDTH  per-master address, master n at [n*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_i  in  2*DATA_WIDTH  per-master write data
m_ack_o  out  2  per-master ack
m_err_o  out  2  per-master err
m_rty_o  out  2  per-master retry
m_dat_o  out  DATA_WIDTH  read data, broadcast to both masters
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err
s_rty_i  in  1  slave retry
s_dat_i  in  DATA_WIDTH  slave read data
grant_o  out  2  one-hot current grant, 00 when idle

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - state IDLE, grant_o=00, last-served pointer=1 (so master 0 wins first tie).
  - All slave outputs and all m_*_o outputs are 0 while not granted.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - If exactly one m_cyc_i bit is set, go to that master's GNT state.
  - If both are set, grant the master that is not the last served.
  - Grant is registered: request seen at edge N, s_cyc_o asserted during cycle N+1. Arbitration latency is one clock.
- GNTn:
  - s_cyc_o=m_cyc_i[n], s_stb_o=m_cyc_i[n]&m_stb_i[n]; s_we_o, s_adr_o and s_dat_o muxed combinationally from master n.
  - m_ack_o[n]=s_ack_i, m_err_o[n]=s_err_i, m_rty_o[n]=s_rty_i.
  - The other master's ack/err/rty are forced to 0.
  - m_dat_o=s_dat_i in all states.
- Release:
  - When m_cyc_i[n] is sampled low in GNTn, go to IDLE and set last-served=n.
  - The next grant comes at the earliest one cycle later, which gives one guaranteed idle bus cycle between owners.
  - A master holding cyc across several strobes keeps the bus; there is no preemption.
- Simultaneous events:
  - Master n dropping cyc in the same edge that the other master raises cyc: go to IDLE, then grant the other master.
  - Response to a master that has already dropped cyc is ignored.
- A grant is never issued to a master whose cyc is low at the deciding edge.
- Reset mid-cycle: bus released immediately, no response generated.

Optional Feature:
Macro WISHBONE_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter (sized $clog2(TIMEOUT_CYCLES+1)) is cleared on entry to GNTn and on any s_ack_i/s_err_i/s_rty_i.
  - It increments while s_stb_o is high with no response.
  - On reaching TIMEOUT_CYCLES, the arbiter pulses m_err_o[n] for one cycle, forces s_cyc_o/s_stb_o low from the next cycle, and waits in GNTn until master n drops cyc.
- Not defined: no counter exists, and a stalled slave holds the bus indefinitely.

Decomposition:
- Package wishbone_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - arb_state_t enum (IDLE, GNT0, GNT1).
  - Master index constants MASTER_UART=0, MASTER_ENGINE=1.
- No sub-module needed; a single flat module of about 150-250 lines.

Test Plan:
- Reset with both masters requesting, release rst_ni -> grant_o=01 one cycle later and s_adr_o equals master 0's address.
- Master 1 alone reads 0x000123, slave returns 0xA5 with ack -> m_ack_o=10, m_dat_o=0xA5, m_ack_o[0] stays 0.
- Both masters hold cyc continuously with 1-strobe cycles -> grants alternate 01,00,10,00,01…, each master gets exactly one transaction per round.
- Master 0 burst of 4 writes under one cyc while master 1 requests -> all 4 writes reach the slave before grant_o becomes 10.
- Master 0 drops cyc in the same edge master 1 raises it -> one IDLE cycle, then grant_o=10.
- With WISHBONE_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks -> m_err_o[0] pulses exactly 16 cycles after stb, s_cyc_o low afterwards, master 1 granted once master 0 drops cyc.

Source files
------------

// File: rtl/wishbone_pkg.sv
// Shared types and constants for the two-master Wishbone classic arbiter.
package wishbone_pkg;

  localparam int WB_ADDR_WIDTH = 23;
  localparam int WB_DATA_WIDTH = 8;

  localparam int MASTER_UART   = 0;
  localparam int MASTER_ENGINE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wishbone_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with registered, cycle-held grants.
// Optional slave watchdog enabled by defining WISHBONE_ARBITER_TIMEOUT_EN.
`default_nettype none

module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              m_cyc_i,
  input  logic [1:0]              m_stb_i,
  input  logic [1:0]              m_we_i,
  input  logic [2*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [2*DATA_WIDTH-1:0] m_dat_i,
  output logic [1:0]              m_ack_o,
  output logic [1:0]              m_err_o,
  output logic [1:0]              m_rty_o,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [1:0]              grant_o
);

  arb_state_t state, next_state;
  logic       last_served;
  logic [1:0] grant;
  logic [1:0] resp_en;
  logic       owner_cyc;
  logic       owner_stb;
  logic       expired;
  logic       timeout_hit;
  logic [ADDR_WIDTH-1:0] adr_sel;
  logic [DATA_WIDTH-1:0] dat_sel;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        case (m_cyc_i)
          2'b01:   next_state = GNT0;
          2'b10:   next_state = GNT1;
          // On a tie the master that was not served last wins.
          2'b11:   next_state = last_served ? GNT0 : GNT1;
          default: next_state = IDLE;
        endcase
      end
      GNT0:    if (!m_cyc_i[MASTER_UART])   next_state = IDLE;
      GNT1:    if (!m_cyc_i[MASTER_ENGINE]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state <= next_state;
      if (state == GNT0 && !m_cyc_i[MASTER_UART])   last_served <= 1'b0;
      if (state == GNT1 && !m_cyc_i[MASTER_ENGINE]) last_served <= 1'b1;
    end
  end

  assign grant[MASTER_UART]   = (state == GNT0);
  assign grant[MASTER_ENGINE] = (state == GNT1);
  assign grant_o              = grant;

  assign owner_cyc = |(grant & m_cyc_i);
  assign owner_stb = |(grant & m_stb_i);

  always_comb begin
    adr_sel = '0;
    dat_sel = '0;
    if (grant[MASTER_UART]) begin
      adr_sel = m_adr_i[MASTER_UART*ADDR_WIDTH +: ADDR_WIDTH];
      dat_sel = m_dat_i[MASTER_UART*DATA_WIDTH +: DATA_WIDTH];
    end else if (grant[MASTER_ENGINE]) begin
      adr_sel = m_adr_i[MASTER_ENGINE*ADDR_WIDTH +: ADDR_WIDTH];
      dat_sel = m_dat_i[MASTER_ENGINE*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign s_cyc_o = owner_cyc & ~expired;
  assign s_stb_o = s_cyc_o & owner_stb;
  assign s_we_o  = |(grant & m_we_i);
  assign s_adr_o = adr_sel;
  assign s_dat_o = dat_sel;

  // Responses reach only the owner, and only while it still holds cyc.
  assign resp_en = grant & m_cyc_i;
  assign m_ack_o = resp_en & {2{s_ack_i}};
  assign m_err_o = resp_en & {2{s_err_i | timeout_hit}};
  assign m_rty_o = resp_en & {2{s_rty_i}};
  assign m_dat_o = s_dat_i;

`ifdef WISHBONE_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expired;

  // Counter saturates at LIMIT; the error pulses once, then the bus stays parked.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || state == IDLE) begin
      wd_cnt     <= '0;
      wd_expired <= 1'b0;
    end else begin
      if (s_ack_i || s_err_i || s_rty_i) wd_cnt <= '0;
      else if (s_stb_o && wd_cnt != LIMIT) wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit) wd_expired <= 1'b1;
    end
  end

  assign timeout_hit = (wd_cnt == LIMIT) && !wd_expired;
  assign expired     = wd_expired;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign expired        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter: vector table, directed corners, randomized model compare.
`default_nettype none

module tb_wishbone_arbiter;
  localparam int AW = 23;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [2*AW-1:0] m_adr;
  logic [2*DW-1:0] m_dat;
  logic [1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [DW-1:0] m_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_dat;
  logic [1:0]    grant_o;

  always #5 clk = ~clk;

  wishbone_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat),
    .grant_o(grant_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]    cyc, stb, we;
    logic          ack;
    logic [7:0]    sdat;
    logic [1:0]    e_gnt;
    logic          e_scyc;
    logic [AW-1:0] e_sadr;
    logic [1:0]    e_mack;
  } vec_t;

  vec_t vt[10];

  // Reference model: who owns the bus, who was served last, watchdog progress.
  int owner, last, wd;
  bit expired;

  task automatic model_init();
    owner = -1; last = 1; wd = 0; expired = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int writes, n_tx, prev, first_stb, first_err;
    logic [1:0] got;

    vt[0] = '{2'b11, 2'b11, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 23'h000000, 2'b00};
    vt[1] = '{2'b11, 2'b11, 2'b00, 1'b1, 8'h11, 2'b01, 1'b1, 23'h000AAA, 2'b01};
    vt[2] = '{2'b10, 2'b10, 2'b00, 1'b0, 8'h00, 2'b01, 1'b0, 23'h000AAA, 2'b00};
    vt[3] = '{2'b10, 2'b10, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 23'h000000, 2'b00};
    vt[4] = '{2'b10, 2'b10, 2'b10, 1'b1, 8'hA5, 2'b10, 1'b1, 23'h000123, 2'b10};
    vt[5] = '{2'b01, 2'b01, 2'b00, 1'b0, 8'h00, 2'b10, 1'b0, 23'h000123, 2'b00};
    vt[6] = '{2'b01, 2'b01, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 23'h000000, 2'b00};
    vt[7] = '{2'b01, 2'b01, 2'b00, 1'b1, 8'h3C, 2'b01, 1'b1, 23'h000AAA, 2'b01};
    vt[8] = '{2'b00, 2'b00, 2'b00, 1'b1, 8'h3C, 2'b01, 1'b0, 23'h000AAA, 2'b00};
    vt[9] = '{2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 23'h000000, 2'b00};

    rst_ni = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    m_adr = {23'h000123, 23'h000AAA}; m_dat = 16'h0; s_ack = 0; s_err = 0; s_rty = 0; s_dat = 8'h0;
    tick(); tick();
    @(negedge clk);
    check("reset", {grant_o, s_cyc_o, s_stb_o, s_adr_o, m_ack_o, m_err_o, m_rty_o}, 64'h0);
    tick();
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) begin
      m_cyc = vt[i].cyc; m_stb = vt[i].stb; m_we = vt[i].we;
      s_ack = vt[i].ack; s_dat = vt[i].sdat;
      @(negedge clk);
      check($sformatf("vec%0d", i), {grant_o, s_cyc_o, s_adr_o, m_ack_o, m_dat_o},
            {vt[i].e_gnt, vt[i].e_scyc, vt[i].e_sadr, vt[i].e_mack, vt[i].sdat});
      tick();
    end

    // Burst: master 0 keeps cyc across four write strobes while master 1 waits.
    m_cyc = 2'b01; m_stb = 2'b00; m_we = 2'b11; s_ack = 1'b0;
    @(negedge clk); check("burst idle", grant_o, 2'b00); tick();
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] ea;
      ea = AW'(32'h100 + i);
      m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
      m_adr[AW-1:0] = ea; m_dat[DW-1:0] = 8'(8'h10 + i);
      @(negedge clk);
      check("burst beat", {grant_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o},
            {2'b01, 1'b1, 1'b1, ea, 8'(8'h10 + i), 2'b01});
      if (grant_o == 2'b01 && s_stb_o && s_we_o && s_ack) writes++;
      tick();
    end
    m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b0;
    @(negedge clk); check("burst release", {grant_o, s_cyc_o}, {2'b01, 1'b0}); tick();
    @(negedge clk); check("burst gap", grant_o, 2'b00); tick();
    @(negedge clk); check("burst handover", {grant_o, s_cyc_o}, {2'b10, 1'b1});
    check("burst writes", writes, 4);
    tick();

    // Round robin: each master drops cyc for one cycle after every ack.
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    tick(); tick();
    got = 2'b00; n_tx = 0; prev = -1; s_ack = 1'b1;
    for (int c = 0; c < 24; c++) begin
      m_cyc = ~got; m_stb = ~got;
      @(negedge clk);
      if (m_ack_o == 2'b11) check("rr double ack", m_ack_o, 2'b00);
      if (m_ack_o != 2'b00) begin
        if (prev >= 0) check("rr alternate", m_ack_o, (prev == 0) ? 2'b10 : 2'b01);
        prev = (m_ack_o == 2'b01) ? 0 : 1;
        n_tx++;
      end
      got = m_ack_o;
      tick();
    end
    check("rr transactions", n_tx, 8);
    s_ack = 1'b0;

    // Randomized run against the reference model, including occasional resets.
    rst_ni = 1'b0; tick(); model_init();
    for (int it = 0; it < 3000; it++) begin
      logic [1:0]    e_gnt, e_ack, e_err, e_rty;
      logic          e_scyc, e_sstb, e_swe, own_cyc, hit, quiet;
      logic [AW-1:0] e_sadr;
      logic [DW-1:0] e_sdat;
      quiet = (it >= 1000 && it < 1400);
      rst_ni = ($urandom_range(99) != 0);
      if ($urandom_range(3) == 0) m_cyc[0] = ~m_cyc[0];
      if ($urandom_range(3) == 0) m_cyc[1] = ~m_cyc[1];
      m_stb = 2'($urandom); m_we = 2'($urandom);
      m_adr = (2*AW)'({$urandom, $urandom}); m_dat = 16'($urandom);
      s_ack = !quiet && ($urandom_range(2) == 0);
      s_err = !quiet && ($urandom_range(7) == 0);
      s_rty = !quiet && ($urandom_range(7) == 0);
      s_dat = 8'($urandom);
      @(negedge clk);
      own_cyc = (owner >= 0) && m_cyc[owner];
`ifdef WISHBONE_ARBITER_TIMEOUT_EN
      hit = (owner >= 0) && (wd == TO) && !expired;
`else
      hit = 1'b0;
`endif
      e_gnt  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      e_scyc = own_cyc && !expired;
      e_sstb = e_scyc && m_stb[owner];
      e_swe  = (owner >= 0) && m_we[owner];
      e_sadr = (owner >= 0) ? m_adr[owner*AW +: AW] : '0;
      e_sdat = (owner >= 0) ? m_dat[owner*DW +: DW] : '0;
      e_ack  = (own_cyc && s_ack) ? e_gnt : 2'b00;
      e_err  = (own_cyc && (s_err || hit)) ? e_gnt : 2'b00;
      e_rty  = (own_cyc && s_rty) ? e_gnt : 2'b00;
      check("random", {grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_err_o, m_rty_o, m_dat_o},
            {e_gnt, e_scyc, e_sstb, e_swe, e_sadr, e_sdat, e_ack, e_err, e_rty, s_dat});
      if (!rst_ni) model_init();
      else if (owner < 0) begin
        wd = 0; expired = 0;
        if (m_cyc == 2'b01) owner = 0;
        else if (m_cyc == 2'b10) owner = 1;
        else if (m_cyc == 2'b11) owner = (last == 1) ? 0 : 1;
      end else if (!m_cyc[owner]) begin
        last = owner; owner = -1;
      end else begin
        if (s_ack || s_err || s_rty) wd = 0;
        else if (e_sstb && wd < TO) wd++;
        if (hit) expired = 1;
      end
      tick();
    end
    rst_ni = 1'b1;

`ifdef WISHBONE_ARBITER_TIMEOUT_EN
    // Stalled slave: error after TO cycles of unanswered strobe, then the bus parks.
    rst_ni = 1'b0; m_cyc = 2'b00; m_stb = 2'b00; s_ack = 0; s_err = 0; s_rty = 0;
    tick(); rst_ni = 1'b1;
    m_cyc = 2'b01; m_stb = 2'b01;
    first_stb = -1; first_err = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_stb_o && first_stb < 0) first_stb = c;
      if (m_err_o[0] && first_err < 0) first_err = c;
      tick();
      if (first_err >= 0) break;
    end
    check("timeout err seen", first_err >= 0, 1'b1);
    check("timeout latency", first_err - first_stb, TO);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("timeout parked", {s_cyc_o, s_stb_o, m_err_o, grant_o}, {1'b0, 1'b0, 2'b00, 2'b01});
      tick();
    end
    m_cyc = 2'b10; m_stb = 2'b10;
    @(negedge clk); check("timeout drop", grant_o, 2'b01); tick();
    @(negedge clk); check("timeout gap", grant_o, 2'b00); tick();
    @(negedge clk); check("timeout handover", {grant_o, s_cyc_o}, {2'b10, 1'b1}); tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
